// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the valid/ready FIFO controller and its output buffer.
package fifo_pkg;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_occ_e;

    localparam int BUF_DEPTH = 2;

    // One extra bit above the address is the wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // RAM entries + one read in flight + two buffered words.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 3);
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry in-order output buffer; entry 0 is always the head.
//   state     | meaning
//   BUF_EMPTY | no words held, head invalid
//   BUF_ONE   | head word in entry 0
//   BUF_TWO   | head in entry 0, next word in entry 1
module fifo_skid2 import fifo_pkg::*; #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] push_data_i,
    input  logic               pop_i,
    output logic               head_valid_o,
    output logic [width_p-1:0] head_data_o,
    output buf_occ_e           occ_o
);

    buf_occ_e           r_occ, w_occ_nxt;
    logic [width_p-1:0] r_e0, r_e1, w_e0_nxt, w_e1_nxt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_occ <= BUF_EMPTY;
            r_e0  <= '0;
            r_e1  <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            r_e0  <= w_e0_nxt;
            r_e1  <= w_e1_nxt;
        end
    end

    always_comb begin
        w_occ_nxt = r_occ;
        w_e0_nxt  = r_e0;
        w_e1_nxt  = r_e1;
        case (r_occ)
            BUF_EMPTY: begin
                if (push_i) begin
                    w_e0_nxt  = push_data_i;
                    w_occ_nxt = BUF_ONE;
                end
            end
            BUF_ONE: begin
                case ({push_i, pop_i})
                    2'b10: begin
                        w_e1_nxt  = push_data_i;
                        w_occ_nxt = BUF_TWO;
                    end
                    2'b01:   w_occ_nxt = BUF_EMPTY;
                    2'b11:   w_e0_nxt  = push_data_i;
                    default: w_occ_nxt = r_occ;
                endcase
            end
            BUF_TWO: begin
                if (pop_i) begin
                    w_e0_nxt = r_e1;
                    if (push_i)
                        w_e1_nxt = push_data_i;
                    else
                        w_occ_nxt = BUF_ONE;
                end
            end
            default: w_occ_nxt = BUF_EMPTY;
        endcase
    end

    assign head_valid_o = (r_occ != BUF_EMPTY);
    assign head_data_o  = r_e0;
    assign occ_o        = r_occ;

    // The controller's credit rule must keep a push away from a full, non-popping buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && !pop_i && (r_occ == BUF_TWO)));

endmodule

// File: rtl/ram_1r1w_sync.sv
// Simple dual-port RAM with one registered read port; a read that collides with a
// same-cycle write to the same address returns the old contents.
module ram_1r1w_sync #(
    parameter int width_p = 8,
    parameter int depth_p = 512
) (
    input  logic                       clk_i,
    input  logic                       wr_valid_i,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [width_p-1:0]         wr_data_i,
    input  logic                       rd_valid_i,
    input  logic [$clog2(depth_p)-1:0] rd_addr_i,
    output logic [width_p-1:0]         rd_data_o
);

    logic [width_p-1:0] r_mem [depth_p];
    logic [width_p-1:0] r_rd_data;

    always_ff @(posedge clk_i) begin
        if (wr_valid_i)
            r_mem[wr_addr_i] <= wr_data_i;
        if (rd_valid_i)
            r_rd_data <= r_mem[rd_addr_i];
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/fifo_1r1w_ctrl.sv
// Valid/ready FIFO controller over an external 1R1W synchronous RAM plus a 2-entry output buffer.
// Define FIFO_BYPASS_EN to let words skip the RAM when nothing older is stored or in flight.
module fifo_1r1w_ctrl import fifo_pkg::*; #(
    parameter int width_p = 8,
    parameter int depth_p = 512
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(depth_p+3)-1:0] count_o,
    output logic                         ram_wr_valid_o,
    output logic [$clog2(depth_p)-1:0]   ram_wr_addr_o,
    output logic [width_p-1:0]           ram_wr_data_o,
    output logic                         ram_rd_valid_o,
    output logic [$clog2(depth_p)-1:0]   ram_rd_addr_o,
    input  logic [width_p-1:0]           ram_rd_data_i
);

    localparam int AW = $clog2(depth_p);
    localparam int PW = ptr_w(depth_p);
    localparam int CW = cnt_w(depth_p);

    logic [PW-1:0]      r_wr_ptr, r_rd_ptr, w_ram_cnt;
    logic               r_inflight;
    logic [CW-1:0]      r_count;
    logic               w_enq, w_deq, w_credit, w_bypass;
    logic               w_push, w_head_valid;
    logic [width_p-1:0] w_push_data, w_head_data;
    logic [2:0]         w_occ_sum;
    buf_occ_e           w_occ;

    assign w_ram_cnt = r_wr_ptr - r_rd_ptr;

    // Gating with reset_i keeps ready_o low for the whole reset pulse.
    assign ready_o = !reset_i && (w_ram_cnt < PW'(depth_p));
    assign w_enq   = valid_i && ready_o;
    assign w_deq   = w_head_valid && ready_i;

    assign w_occ_sum = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_credit  = (w_occ_sum < 3'd2);

`ifdef FIFO_BYPASS_EN
    assign w_bypass = w_enq && (w_ram_cnt == '0) && !r_inflight && w_credit;
`else
    assign w_bypass = 1'b0;
`endif

    assign ram_wr_valid_o = w_enq && !w_bypass;
    assign ram_wr_addr_o  = r_wr_ptr[AW-1:0];
    assign ram_wr_data_o  = data_i;

    // ram_cnt only reflects earlier writes, so a read never targets this cycle's write.
    assign ram_rd_valid_o = (w_ram_cnt != '0) && w_credit;
    assign ram_rd_addr_o  = r_rd_ptr[AW-1:0];

    assign w_push      = r_inflight || w_bypass;
    assign w_push_data = r_inflight ? ram_rd_data_i : data_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + {{(PW-1){1'b0}}, ram_wr_valid_o};
            r_rd_ptr   <= r_rd_ptr + {{(PW-1){1'b0}}, ram_rd_valid_o};
            r_inflight <= ram_rd_valid_o;
            r_count    <= r_count + {{(CW-1){1'b0}}, w_enq} - {{(CW-1){1'b0}}, w_deq};
        end
    end

    fifo_skid2 #(.width_p(width_p)) u_skid (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (w_push),
        .push_data_i  (w_push_data),
        .pop_i        (w_deq),
        .head_valid_o (w_head_valid),
        .head_data_o  (w_head_data),
        .occ_o        (w_occ)
    );

    assign valid_o = w_head_valid;
    assign data_o  = w_head_data;
    assign count_o = r_count;

endmodule
